// File: rtl/obi_pkg.sv
// Shared OBI bus constants and the request bundle carried from each master
// to the shared slave port.
package obi_pkg;

  localparam int OBI_AW  = 32;
  localparam int OBI_DW  = 32;
  localparam int OBI_BEW = 4;

  typedef struct packed {
    logic               we;
    logic [OBI_BEW-1:0] be;
    logic [OBI_AW-1:0]  addr;
    logic [OBI_DW-1:0]  wdata;
  } obi_req_t;

endpackage

// File: rtl/obi_id_fifo.sv
// In-order FIFO of granted master indices. The head is valid whenever
// empty_o is low. A push is not visible at the head until the next cycle.
module obi_id_fifo #(
  parameter int DEPTH = 2,
  parameter int IDW   = 1
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           push_i,
  input  logic [IDW-1:0] data_i,
  input  logic           pop_i,
  output logic [IDW-1:0] data_o,
  output logic           full_o,
  output logic           empty_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [IDW-1:0] mem [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [CW-1:0]  count;
  logic           do_push;
  logic           do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
    return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
  endfunction

  assign full_o  = (count == CW'(DEPTH));
  assign empty_o = (count == '0);
  assign data_o  = mem[rd_ptr];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (do_pop && !do_push) count <= count - CW'(1);
    end
  end

  // NOTE: storage has no reset; entries are only read once count marks them
  // valid, so clearing them would add reset fan-out for no behavioural gain.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= data_i;
  end

endmodule

// File: rtl/obi_rr_arbiter.sv
// Round-robin arbiter sharing one OBI slave port among NUM_MASTERS masters;
// an ID FIFO returns each response to the master that issued the request.
module obi_rr_arbiter
  import obi_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int DEPTH       = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_MASTERS-1:0]        m_req_i,
  input  logic [NUM_MASTERS-1:0]        m_we_i,
  input  logic [NUM_MASTERS*4-1:0]      m_be_i,
  input  logic [NUM_MASTERS*32-1:0]     m_addr_i,
  input  logic [NUM_MASTERS*32-1:0]     m_wdata_i,
  output logic [NUM_MASTERS-1:0]        m_gnt_o,
  output logic [NUM_MASTERS-1:0]        m_rvalid_o,
  output logic [NUM_MASTERS*32-1:0]     m_rdata_o,
  output logic                          s_req_o,
  output logic                          s_we_o,
  output logic [3:0]                    s_be_o,
  output logic [31:0]                   s_addr_o,
  output logic [31:0]                   s_wdata_o,
  input  logic                          s_gnt_i,
  input  logic                          s_rvalid_i,
  input  logic [31:0]                   s_rdata_i,
  output logic                          rsp_err_o
);

  localparam int IDW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  obi_req_t       reqs [NUM_MASTERS];
  obi_req_t       sel;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] winner;
  logic           any_req;
  logic           accept;
  logic           fifo_full;
  logic           fifo_empty;
  logic [IDW-1:0] head;
  logic           rsp_hit;
  logic           rsp_spurious;

  // NOTE: every always_comb output gets a default before any branch, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    for (int k = 0; k < NUM_MASTERS; k++) begin
      reqs[k]       = '0;
      reqs[k].we    = m_we_i[k];
      reqs[k].be    = m_be_i[k*OBI_BEW +: OBI_BEW];
      reqs[k].addr  = m_addr_i[k*OBI_AW +: OBI_AW];
      reqs[k].wdata = m_wdata_i[k*OBI_DW +: OBI_DW];
    end
  end

  // Scan downward so the requester closest to rr_ptr is written last and wins.
  always_comb begin
    logic [IDW-1:0] cand;
    cand   = '0;
    winner = rr_ptr;
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      cand = IDW'((int'(rr_ptr) + i) % NUM_MASTERS);
      if (m_req_i[cand]) winner = cand;
    end
  end

  assign any_req = |m_req_i;

  // A pop in the same cycle never frees a slot early: keeps s_rvalid_i off
  // the combinational path to the grant.
  assign s_req_o = any_req & ~fifo_full & ~rst_i;
  assign accept  = s_req_o & s_gnt_i;

  assign sel       = any_req ? reqs[winner] : '0;
  assign s_we_o    = sel.we;
  assign s_be_o    = sel.be;
  assign s_addr_o  = sel.addr;
  assign s_wdata_o = sel.wdata;

  always_comb begin
    m_gnt_o = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (accept && winner == IDW'(k)) m_gnt_o[k] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr <= '0;
    end else if (accept) begin
      rr_ptr <= (winner == IDW'(NUM_MASTERS - 1)) ? '0 : winner + IDW'(1);
    end
  end

  obi_id_fifo #(
    .DEPTH (DEPTH),
    .IDW   (IDW)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (accept),
    .data_i  (winner),
    .pop_i   (rsp_hit),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign rsp_hit      = s_rvalid_i & ~fifo_empty;
  assign rsp_spurious = s_rvalid_i & fifo_empty;

  always_comb begin
    m_rvalid_o = '0;
    m_rdata_o  = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (rsp_hit && head == IDW'(k)) begin
        m_rvalid_o[k]                 = 1'b1;
        m_rdata_o[k*OBI_DW +: OBI_DW] = s_rdata_i;
      end
    end
  end

  // Sticky until reset; responses left over from before a reset land here.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rsp_err_o <= 1'b0;
    end else if (rsp_spurious) begin
      rsp_err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_obi_rr_arbiter.sv
// Directed and randomized checks of obi_rr_arbiter against a queue-based
// model of outstanding transactions and a round-robin pointer.
module tb_obi_rr_arbiter;

  localparam int N     = 2;
  localparam int DEPTH = 2;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic [N-1:0]  m_req_i = '0;
  logic [N-1:0]  m_we_i = '0;
  logic [N*4-1:0]  m_be_i = '0;
  logic [N*32-1:0] m_addr_i = '0;
  logic [N*32-1:0] m_wdata_i = '0;
  logic [N-1:0]  m_gnt_o;
  logic [N-1:0]  m_rvalid_o;
  logic [N*32-1:0] m_rdata_o;
  logic          s_req_o;
  logic          s_we_o;
  logic [3:0]    s_be_o;
  logic [31:0]   s_addr_o;
  logic [31:0]   s_wdata_o;
  logic          s_gnt_i = 1'b0;
  logic          s_rvalid_i = 1'b0;
  logic [31:0]   s_rdata_i = '0;
  logic          rsp_err_o;

  int checks = 0;
  int errors = 0;

  // Reference model: outstanding master IDs in issue order, next-priority
  // master, sticky error bit.
  int q[$];
  int rr = 0;
  bit err_m = 1'b0;

  always #5 clk_i = ~clk_i;

  obi_rr_arbiter #(
    .NUM_MASTERS (N),
    .DEPTH       (DEPTH)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .m_req_i    (m_req_i),
    .m_we_i     (m_we_i),
    .m_be_i     (m_be_i),
    .m_addr_i   (m_addr_i),
    .m_wdata_i  (m_wdata_i),
    .m_gnt_o    (m_gnt_o),
    .m_rvalid_o (m_rvalid_o),
    .m_rdata_o  (m_rdata_o),
    .s_req_o    (s_req_o),
    .s_we_o     (s_we_o),
    .s_be_o     (s_be_o),
    .s_addr_o   (s_addr_o),
    .s_wdata_o  (s_wdata_o),
    .s_gnt_i    (s_gnt_i),
    .s_rvalid_i (s_rvalid_i),
    .s_rdata_i  (s_rdata_i),
    .rsp_err_o  (rsp_err_o)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_master(input int k, input logic we, input logic [3:0] be,
                            input logic [31:0] addr, input logic [31:0] wdata);
    m_we_i[k]            = we;
    m_be_i[k*4 +: 4]     = be;
    m_addr_i[k*32 +: 32] = addr;
    m_wdata_i[k*32 +: 32] = wdata;
  endtask

  // Called just after a negedge with inputs applied: compare all outputs with
  // the model, advance the model as the coming edge will, wait for next negedge.
  task automatic step(input string tag);
    int          win;
    bit          e_sreq;
    logic [N-1:0] e_gnt;
    logic [N-1:0] e_rv;
    logic [N*32-1:0] e_rd;
    logic        e_we;
    logic [3:0]  e_be;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    #1;
    win = -1;
    for (int off = 0; off < N; off++) begin
      if (win < 0 && m_req_i[(rr + off) % N]) win = (rr + off) % N;
    end
    e_sreq  = (win >= 0) && (q.size() < DEPTH);
    e_gnt   = '0;
    e_we    = 1'b0;
    e_be    = '0;
    e_addr  = '0;
    e_wdata = '0;
    if (win >= 0) begin
      e_we    = m_we_i[win];
      e_be    = m_be_i[win*4 +: 4];
      e_addr  = m_addr_i[win*32 +: 32];
      e_wdata = m_wdata_i[win*32 +: 32];
      if (e_sreq && s_gnt_i) e_gnt[win] = 1'b1;
    end
    e_rv = '0;
    e_rd = '0;
    if (s_rvalid_i && q.size() > 0) begin
      e_rv[q[0]]          = 1'b1;
      e_rd[q[0]*32 +: 32] = s_rdata_i;
    end
    check({tag, ".s_req"},    64'(s_req_o),    64'(e_sreq));
    check({tag, ".s_we"},     64'(s_we_o),     64'(e_we));
    check({tag, ".s_be"},     64'(s_be_o),     64'(e_be));
    check({tag, ".s_addr"},   64'(s_addr_o),   64'(e_addr));
    check({tag, ".s_wdata"},  64'(s_wdata_o),  64'(e_wdata));
    check({tag, ".m_gnt"},    64'(m_gnt_o),    64'(e_gnt));
    check({tag, ".m_rvalid"}, 64'(m_rvalid_o), 64'(e_rv));
    check({tag, ".m_rdata"},  64'(m_rdata_o),  64'(e_rd));
    check({tag, ".rsp_err"},  64'(rsp_err_o),  64'(err_m));
    if (s_rvalid_i) begin
      if (q.size() > 0) void'(q.pop_front());
      else              err_m = 1'b1;
    end
    if (e_sreq && s_gnt_i) begin
      q.push_back(win);
      rr = (win + 1) % N;
    end
    @(negedge clk_i);
  endtask

  task automatic do_reset(input string tag);
    rst_i = 1'b1;
    #1;
    check({tag, ".rst_s_req"},    64'(s_req_o),    64'd0);
    check({tag, ".rst_m_gnt"},    64'(m_gnt_o),    64'd0);
    check({tag, ".rst_m_rvalid"}, 64'(m_rvalid_o), 64'd0);
    check({tag, ".rst_rsp_err"},  64'(rsp_err_o),  64'd0);
    q.delete();
    rr    = 0;
    err_m = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  initial begin
    @(negedge clk_i);
    m_req_i    = 2'b11;
    s_gnt_i    = 1'b1;
    s_rvalid_i = 1'b1;
    do_reset("por");
    m_req_i    = '0;
    s_rvalid_i = 1'b0;

    // 1. single master read
    set_master(0, 1'b0, 4'hF, 32'h0000_0004, 32'h0);
    m_req_i = 2'b01;
    s_gnt_i = 1'b1;
    #1 check("t1.gnt0", 64'(m_gnt_o), 64'h1);
    step("t1.c0");
    m_req_i    = 2'b00;
    s_rvalid_i = 1'b1;
    s_rdata_i  = 32'hDEAD_BEEF;
    #1 check("t1.rvalid", 64'(m_rvalid_o), 64'h1);
    check("t1.rdata0", 64'(m_rdata_o[31:0]), 64'hDEAD_BEEF);
    step("t1.c1");
    s_rvalid_i = 1'b0;

    // 2. contention with one-cycle responses
    do_reset("t2");
    set_master(0, 1'b1, 4'h3, 32'h1000_0000, 32'hAAAA_0000);
    set_master(1, 1'b0, 4'hC, 32'h2000_0000, 32'hBBBB_1111);
    m_req_i = 2'b11;
    s_gnt_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      s_rvalid_i = (q.size() > 0);
      s_rdata_i  = $urandom();
      #1 check($sformatf("t2.gnt%0d", i), 64'(m_gnt_o), (i % 2 == 0) ? 64'h1 : 64'h2);
      step($sformatf("t2.c%0d", i));
    end
    m_req_i    = '0;
    s_rvalid_i = 1'b1;
    step("t2.drain");
    s_rvalid_i = 1'b0;

    // 3. backpressure until the ID FIFO is full
    do_reset("t3");
    m_req_i = 2'b01;
    s_gnt_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1 check($sformatf("t3.sreq%0d", i), 64'(s_req_o), (i < 2) ? 64'h1 : 64'h0);
      step($sformatf("t3.c%0d", i));
    end
    s_rvalid_i = 1'b1;
    s_rdata_i  = 32'h1234_5678;
    #1 check("t3.sreq_pop", 64'(s_req_o), 64'h0);
    step("t3.pop");
    s_rvalid_i = 1'b0;
    #1 check("t3.sreq_after", 64'(s_req_o), 64'h1);
    step("t3.resume");
    m_req_i    = '0;
    s_rvalid_i = 1'b1;
    step("t3.drain0");
    step("t3.drain1");
    s_rvalid_i = 1'b0;

    // 4. slave stall with master 1 requesting
    do_reset("t4");
    set_master(1, 1'b1, 4'h5, 32'hCAFE_0010, 32'h5555_AAAA);
    m_req_i = 2'b10;
    s_gnt_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 check($sformatf("t4.addr%0d", i), 64'(s_addr_o), 64'hCAFE_0010);
      step($sformatf("t4.stall%0d", i));
    end
    s_gnt_i = 1'b1;
    #1 check("t4.gnt1", 64'(m_gnt_o), 64'h2);
    step("t4.gnt");
    m_req_i    = '0;
    s_rvalid_i = 1'b1;
    s_rdata_i  = 32'h0BAD_F00D;
    step("t4.rsp");
    s_rvalid_i = 1'b0;

    // 5. spurious response
    do_reset("t5");
    s_rvalid_i = 1'b1;
    s_rdata_i  = 32'hFFFF_FFFF;
    #1 check("t5.err_before", 64'(rsp_err_o), 64'h0);
    step("t5.spur");
    s_rvalid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 check($sformatf("t5.sticky%0d", i), 64'(rsp_err_o), 64'h1);
      step($sformatf("t5.hold%0d", i));
    end

    // 6. reset with two transactions outstanding
    do_reset("t6a");
    m_req_i = 2'b11;
    s_gnt_i = 1'b1;
    step("t6.acc0");
    step("t6.acc1");
    m_req_i = '0;
    do_reset("t6b");
    s_rvalid_i = 1'b1;
    s_rdata_i  = 32'h7777_7777;
    #1 check("t6.no_route", 64'(m_rvalid_o), 64'h0);
    step("t6.late_rsp");
    s_rvalid_i = 1'b0;
    #1 check("t6.err_set", 64'(rsp_err_o), 64'h1);
    step("t6.after");

    // Randomized traffic
    do_reset("rnd");
    for (int i = 0; i < 400; i++) begin
      m_req_i = N'($urandom_range(0, (1 << N) - 1));
      for (int k = 0; k < N; k++) begin
        set_master(k, 1'($urandom()), 4'($urandom()), $urandom(), $urandom());
      end
      s_gnt_i    = ($urandom_range(0, 9) < 7);
      s_rvalid_i = ($urandom_range(0, 9) < (q.size() > 0 ? 6 : 1));
      s_rdata_i  = $urandom();
      step($sformatf("rnd%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
